// File: rtl/api_seq_multi_if.sv
// Sequencer <-> tx/rx FIFO and SPI phy bundle.
// master: sequencer side, slave: FIFO/phy side.
interface api_seq_multi_if #(
  parameter int CNT_W = 10
);
  logic             tx_fifo_empty;
  logic             tx_fifo_rd_en;
  logic [31:0]      tx_fifo_dout;
  logic             rx_fifo_wr_en;
  logic [31:0]      rx_fifo_din;
  logic [CNT_W-1:0] rx_fifo_count;
  logic             mosi_vld;
  logic [31:0]      mosi_dat;
  logic             miso_vld;
  logic [31:0]      miso_dat;

  modport master (
    input  tx_fifo_empty,
    input  tx_fifo_dout,
    input  rx_fifo_count,
    input  miso_vld,
    input  miso_dat,
    output tx_fifo_rd_en,
    output rx_fifo_wr_en,
    output rx_fifo_din,
    output mosi_vld,
    output mosi_dat
  );

  modport slave (
    output tx_fifo_empty,
    output tx_fifo_dout,
    output rx_fifo_count,
    output miso_vld,
    output miso_dat,
    input  tx_fifo_rd_en,
    input  rx_fifo_wr_en,
    input  rx_fifo_din,
    input  mosi_vld,
    input  mosi_dat
  );
endinterface

// File: rtl/api_seq_multi.sv
// API channel sequencer: streams tx words per channel through the phy,
// keeps the first RX_BLOCK reply words per chip, tagged with the channel.
// Ports: clk, rst_n, soft_rst, ch_en, chip_num, timeout, state,
//   timer_busy, bus (FIFOs + phy), load, ch_id, nonce_pulse.
module api_seq_multi #(
  parameter int NUM_CH     = 10,
  parameter int CH_W       = 4,
  parameter int WORK_WORDS = 23,
  parameter int RX_BLOCK   = 11,
  parameter int FIFO_DEPTH = 512,
  parameter int CNT_W      = 10,
  parameter int NOP_CYC    = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [3:0]        chip_num,
  input  logic [27:0]       timeout,
  output logic [1:0]        state,
  output logic              timer_busy,
  api_seq_multi_if.master   bus,
  output logic [NUM_CH-1:0] load,
  output logic [CH_W-1:0]   ch_id,
  output logic              nonce_pulse
);

  localparam int IW_W  = $clog2(WORK_WORDS + 1);
  localparam int NOP_W = $clog2(NOP_CYC + 1);
  localparam int IDX_W = $clog2(NUM_CH);

  localparam logic [IW_W-1:0] IW_LAST = IW_W'(WORK_WORDS - 1);
  localparam logic [IW_W-1:0] RX_LIM  = IW_W'(RX_BLOCK);
  localparam logic [IW_W-1:0] RX_TAG  = IW_W'(RX_BLOCK - 1);
  localparam logic [IW_W-1:0] RX_NON  = IW_W'(RX_BLOCK - 2);
  localparam logic [NOP_W-1:0] NOP_LAST = NOP_W'(NOP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WORK = 2'd1,
    S_NOP  = 2'd2
  } st_t;

  st_t              st_q, st_d;
  logic [27:0]      timer_q;
  logic [9:0]       total_q;
  logic [9:0]       wcnt_q;
  logic [9:0]       wcnt_inc;
  logic [IW_W-1:0]  iw_q;
  logic [NOP_W-1:0] nop_q;
  logic             mosi_q;
  logic [CH_W-1:0]  ch_id_q;
  logic [CH_W-1:0]  nxt_ch;
  logic [CNT_W-1:0] cnt_w;
  logic             room_ok;
  logic             go;
  logic             start;
  logic             miso_hit;
  logic             cur_en;

  assign cnt_w      = bus.rx_fifo_count;
  assign timer_busy = (timer_q != 28'd0);
  assign cur_en     = ch_en[IDX_W'(ch_id_q)];

  // Room check in 32 bits so an over-range count cannot wrap.
  assign room_ok = (32'(cnt_w) + 32'(RX_BLOCK) * 32'(chip_num))
                   <= 32'(FIFO_DEPTH);

  assign go = !timer_busy && !bus.tx_fifo_empty && room_ok;

  assign miso_hit = bus.miso_vld && (st_q == S_WORK);
  assign wcnt_inc = wcnt_q + 10'd1;

  always_comb begin
    st_d  = st_q;
    start = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (chip_num != 4'd0) begin
          if (!cur_en) begin
            st_d = S_NOP;
          end else if (go) begin
            st_d  = S_WORK;
            start = 1'b1;
          end
        end
      end
      S_WORK: begin
        if (wcnt_q == total_q) st_d = S_NOP;
      end
      S_NOP: begin
        if (nop_q == NOP_LAST) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  // Next enabled channel after ch_id, wrapping; the smallest
  // offset wins because it is assigned last. Holds if none.
  always_comb begin
    nxt_ch = ch_id_q;
    for (int k = NUM_CH; k >= 1; k--) begin
      int idx;
      idx = int'(ch_id_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (ch_en[IDX_W'(idx)]) nxt_ch = CH_W'(idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      timer_q <= '0;
      total_q <= '0;
      wcnt_q  <= '0;
      iw_q    <= '0;
      nop_q   <= '0;
      mosi_q  <= 1'b0;
      ch_id_q <= '0;
    end else if (soft_rst) begin
      st_q    <= S_IDLE;
      timer_q <= '0;
      total_q <= '0;
      wcnt_q  <= '0;
      iw_q    <= '0;
      nop_q   <= '0;
      mosi_q  <= 1'b0;
      ch_id_q <= '0;
    end else begin
      st_q <= st_d;

      // The start cycle is the first counted one, so the next
      // start lands exactly 'timeout' cycles after this one.
      if (start) begin
        timer_q <= (timeout == 28'd0) ? 28'd0 : timeout - 28'd1;
      end else if (timer_q != 28'd0) begin
        timer_q <= timer_q - 28'd1;
      end

      if (start) begin
        total_q <= 10'(chip_num * WORK_WORDS);
        wcnt_q  <= '0;
        iw_q    <= '0;
      end else if (miso_hit) begin
        wcnt_q <= wcnt_inc;
        iw_q   <= (iw_q == IW_LAST) ? '0 : iw_q + 1'b1;
      end

      // One word outstanding: next request follows each reply.
      mosi_q <= start || (miso_hit && (wcnt_inc < total_q));

      if (st_q == S_NOP) nop_q <= nop_q + 1'b1;
      else               nop_q <= '0;

      if ((st_q == S_NOP) && (st_d == S_IDLE)) ch_id_q <= nxt_ch;
    end
  end

  assign state = st_q;
  assign ch_id = ch_id_q;
  assign load  = ~(NUM_CH'(1) << ch_id_q);

  assign bus.mosi_vld      = mosi_q;
  assign bus.mosi_dat      = bus.tx_fifo_dout;
  assign bus.tx_fifo_rd_en = mosi_q;

  assign bus.rx_fifo_wr_en = miso_hit && (iw_q < RX_LIM);

  // Last kept word of each chip carries the channel tag.
  assign bus.rx_fifo_din =
    (iw_q == RX_TAG) ?
      {bus.miso_dat[31:16], 8'h12, 8'(ch_id_q)} :
      bus.miso_dat;

  assign nonce_pulse = bus.rx_fifo_wr_en && (iw_q == RX_NON) &&
                       (bus.miso_dat == 32'hbeafbeaf);

endmodule
